mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width; byte enables DATA_W/8 bits.
REQ-003 SHALL have parameter TIMEOUT, default 15: max cycles awaiting mem_ack, range 1..255.
REQ-004 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have ports if_req input 1, if_addr input ADDR_W: instruction-fetch read request.
REQ-007 SHALL have ports if_gnt, if_rvalid, if_err output 1 each, and if_rdata output DATA_W: fetch accept, response, error, read data.
REQ-008 SHALL have ports d_req, d_we input 1, d_addr input ADDR_W, d_wdata input DATA_W, d_be input DATA_W/8: data load/store request.
REQ-009 SHALL have ports d_gnt, d_rvalid, d_err output 1 each, and d_rdata output DATA_W: data accept, response, error, read data.
REQ-010 SHALL have ports mem_req, mem_we output 1, mem_addr output ADDR_W, mem_wdata output DATA_W, mem_be output DATA_W/8: unified memory request.
REQ-011 SHALL have ports mem_ack input 1, mem_rdata input DATA_W: memory completion and read data.

Function
REQ-012 SHALL share one memory port between fetch and data; one transaction outstanding.
REQ-013 SHALL use FSM states IDLE, BUSY_IF, BUSY_D, RESP.
REQ-014 IDLE: with one request asserted, SHALL grant it; both asserted: grant the port not granted last (round-robin); after reset, data wins first tie.
REQ-015 Grant SHALL be a 1-cycle *_gnt pulse in the IDLE cycle of acceptance, combinational from req and state; request payload SHALL be registered into mem_* that edge; FSM moves to BUSY_IF/BUSY_D.
REQ-016 In BUSY_*, mem_req SHALL be 1 and mem_* payload stable until mem_ack sampled 1.
REQ-017 On mem_ack, SHALL register mem_rdata into the owner's *_rdata, pulse owner's *_rvalid for exactly 1 cycle next cycle (RESP), and clear mem_req; RESP returns to IDLE.
REQ-018 Minimum latency: gnt cycle N, mem_req high N+1, mem_ack at N+1 gives rvalid at N+2; back-to-back throughput is one transaction per 3 cycles.
REQ-019 Fetches SHALL drive mem_we=0, mem_be all-ones, mem_wdata=0.
REQ-020 Watchdog counter SHALL reset to 0 on grant, increment each BUSY cycle without mem_ack; reaching TIMEOUT SHALL abort: mem_req cleared, owner's *_rvalid and *_err pulse together, rdata=0, go to RESP.
REQ-021 mem_ack arriving in the same cycle the counter reaches TIMEOUT SHALL count as success (no err).
REQ-022 mem_ack sampled while in IDLE or RESP SHALL be ignored.
REQ-023 Requests deasserted before grant SHALL be dropped silently; requester SHALL hold req until gnt.
REQ-024 Non-owner *_rvalid, *_err SHALL stay 0; *_rdata SHALL hold last value between responses.

Reset
REQ-025 Reset asserted SHALL immediately force IDLE, all outputs 0, counter 0, round-robin pointer to "data next".
REQ-026 Reset mid-transaction SHALL abandon it with no rvalid after release; first grant SHALL occur no earlier than first clk edge after release.

Structure
REQ-027 Package riscv_mem_pkg SHALL hold the state enum, ADDR_W/DATA_W defaults, TIMEOUT default.
REQ-028 Round-robin decision SHALL be in sub-module rr_arb2 (2 requesters, last-grant pointer, update-on-grant input).

Verification
REQ-029 Fetch only: if_req, if_addr=0x0000_0010, mem_ack 1 cycle later with mem_rdata=0x0000_0013 -> if_gnt once, mem_we=0, if_rvalid at gnt+2 with if_rdata=0x0000_0013.
REQ-030 Store: d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, d_be=4'b0011 -> mem_* exact, mem_req held through 3 stall cycles, d_rvalid 1 cycle after mem_ack.
REQ-031 Both requesting continuously, 4 transactions -> grant order D, IF, D, IF; no cycle with both gnt.
REQ-032 No mem_ack, TIMEOUT=15 -> mem_req low and d_rvalid=d_err=1 exactly 15 BUSY cycles after grant; ack on the 15th cycle -> no err.
REQ-033 Reset low during BUSY_IF -> all outputs 0 asynchronously; after release, no stale if_rvalid, next tie grants data.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// ============================================================================
//  Package : riscv_mem_pkg
//  Purpose : Shared types and default sizing for the fetch/data memory
//            arbiter (FSM state encoding, port indices, width defaults).
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_mem_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 15;

  // Watchdog counter width; TIMEOUT is limited to 1..255.
  localparam int CNT_W = 8;

  // Requester indices inside the two-way round-robin arbiter.
  localparam int PORT_D  = 0;
  localparam int PORT_IF = 1;

  // Last-grant pointer value after reset: pretending fetch went last makes
  // data win the first tie.
  localparam logic LAST_RESET = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    RESP    = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
//  Module  : rr_arb2
//  Purpose : Two-requester round-robin arbiter with a last-grant pointer.
//            On a tie the requester that was not granted last wins.
//  Ports   : clk      - clock
//            reset    - asynchronous active-low reset
//            req_i    - request vector (bit 0 data, bit 1 fetch)
//            update_i - record the current grant as "last granted"
//            gnt_o    - one-hot (or zero) combinational grant
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import riscv_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o
);

  // 1 = fetch was granted last, 0 = data was granted last.
  logic last_q;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= LAST_RESET;
    end else if (update_i && (gnt_o != 2'b00)) begin
      last_q <= gnt_o[PORT_IF];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module  : mem_arbiter
//  Purpose : Shares one memory port between an instruction-fetch and a data
//            load/store requester, one transaction outstanding at a time,
//            with round-robin tie break and a no-ack watchdog.
//  Ports   : clk, reset (async active-low)
//            if_req/if_addr -> if_gnt, if_rvalid, if_err, if_rdata
//            d_req/d_we/d_addr/d_wdata/d_be -> d_gnt, d_rvalid, d_err, d_rdata
//            mem_req/mem_we/mem_addr/mem_wdata/mem_be <- mem_ack, mem_rdata
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  // instruction fetch
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic                if_err,
  output logic [DATA_W-1:0]   if_rdata,
  // data load/store
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic                d_err,
  output logic [DATA_W-1:0]   d_rdata,
  // unified memory port
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int              BE_W    = DATA_W / 8;
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                rdy_q;

  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [BE_W-1:0]     mem_be_q;
  logic                if_rvalid_q;
  logic                if_err_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic                d_rvalid_q;
  logic                d_err_q;
  logic [DATA_W-1:0]   d_rdata_q;

  logic                accept_open;
  logic [1:0]          arb_gnt;

  // rdy_q stays low until the first edge after reset release, so no grant
  // can be presented in the partial cycle right after reset deasserts.
  assign accept_open = (state_q == IDLE) && rdy_q;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .reset    (reset),
    .req_i    ({if_req, d_req} & {2{accept_open}}),
    .update_i (accept_open),
    .gnt_o    (arb_gnt)
  );

  assign if_gnt = arb_gnt[PORT_IF];
  assign d_gnt  = arb_gnt[PORT_D];

  // Number of BUSY cycles without ack, including the current one.
  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rdy_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      rdy_q       <= 1'b1;
      // Response strobes are single-cycle pulses.
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;

      case (state_q)
        IDLE: begin
          if (d_gnt) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            mem_be_q    <= d_be;
            cnt_q       <= '0;
            state_q     <= BUSY_D;
          end else if (if_gnt) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
            mem_be_q    <= {BE_W{1'b1}};
            cnt_q       <= '0;
            state_q     <= BUSY_IF;
          end
        end

        BUSY_IF, BUSY_D: begin
          // An ack in the very cycle the watchdog expires still wins.
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= RESP;
            if (state_q == BUSY_IF) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= mem_rdata;
            end else begin
              d_rvalid_q  <= 1'b1;
              d_rdata_q   <= mem_rdata;
            end
          end else if (cnt_d == TMO_CNT) begin
            mem_req_q <= 1'b0;
            state_q   <= RESP;
            if (state_q == BUSY_IF) begin
              if_rvalid_q <= 1'b1;
              if_err_q    <= 1'b1;
              if_rdata_q  <= '0;
            end else begin
              d_rvalid_q  <= 1'b1;
              d_err_q     <= 1'b1;
              d_rdata_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        RESP: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_rvalid = if_rvalid_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module  : tb_mem_arbiter
//  Purpose : Self-checking bench for mem_arbiter: directed transaction table,
//            reset-in-flight sequence and a randomized run against a
//            cycle-timeline reference model.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int TMO = 15;
  localparam int NV  = 10;
  localparam int NRAND = 800;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_err    (if_err),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_err     (d_err),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_mem_req"},  64'(mem_req), 64'd0);
    chk({nm, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({nm, "_mem_be"},   64'(mem_be), 64'd0);
    chk({nm, "_mem_we"},   64'(mem_we), 64'd0);
    chk({nm, "_wdata"},    64'(mem_wdata), 64'd0);
    chk({nm, "_gnts"},     64'({if_gnt, d_gnt}), 64'd0);
    chk({nm, "_rvalids"},  64'({if_rvalid, d_rvalid, if_err, d_err}), 64'd0);
    chk({nm, "_rdata"},    64'({if_rdata, d_rdata}), 64'd0);
  endtask

  // One directed transaction: requests, expected owner, ack delay.
  // stall = number of BUSY cycles without ack before ack; >= TMO means never.
  typedef struct {
    logic        if_r;
    logic        d_r;
    logic [31:0] ia;
    logic [31:0] da;
    logic        we;
    logic [31:0] wd;
    logic [3:0]  be;
    int          stall;
    logic [31:0] rd;
    logic        exp_if;
    logic        exp_err;
  } vec_t;

  vec_t        vecs [NV];
  vec_t        v;
  logic [31:0] tb_if_rd, tb_d_rd, exp_rd;
  logic [31:0] e_addr, e_wd;
  logic [3:0]  e_be;
  logic        e_we, ack, done;

  // reference-model state for the randomized run
  bit          in_txn, own_if, last_was_if, exp_err_m, noack;
  bit          e_gi, e_gd, busy, resp;
  int          gcyc, end_k;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'h0,         4'hF, 0,  32'h0000_0013, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h0,         32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 4'h3, 3,  32'h1234_5678, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0200, 1'b0, 32'h0,         4'hF, 1,  32'h0000_00A1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0200, 1'b0, 32'h0,         4'hF, 0,  32'h0000_00A2, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0024, 32'h0000_0204, 1'b1, 32'h0BAD_F00D, 4'hC, 2,  32'h0000_00A3, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0028, 32'h0000_0204, 1'b1, 32'h0BAD_F00D, 4'hC, 0,  32'h0000_00A4, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 32'h0,         32'h0000_0300, 1'b0, 32'h0,         4'hF, TMO, 32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0030, 32'h0,         1'b0, 32'h0,         4'hF, TMO-1, 32'h0000_00B7, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 32'h0000_0034, 32'h0000_0400, 1'b0, 32'h0,         4'h1, 2,  32'h0000_00C8, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 32'h0000_0038, 32'h0,         1'b0, 32'h0,         4'hF, 0,  32'h0000_00C9, 1'b1, 1'b0};

    reset = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0; mem_ack = 1'b0; mem_rdata = '0;

    // ---------------- reset state ----------------
    #2;
    chk_all_zero("reset");
    tick(); tick();
    reset = 1'b1;
    tick();
    tb_if_rd = '0;
    tb_d_rd  = '0;

    // ---------------- directed transaction table ----------------
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      if_req = v.if_r; d_req = v.d_r; if_addr = v.ia; d_addr = v.da;
      d_we = v.we; d_wdata = v.wd; d_be = v.be; mem_ack = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_if_gnt", i), 64'(if_gnt), 64'(v.exp_if));
      chk($sformatf("v%0d_d_gnt", i),  64'(d_gnt),  64'(!v.exp_if));
      e_addr = v.exp_if ? v.ia : v.da;
      e_we   = v.exp_if ? 1'b0 : v.we;
      e_be   = v.exp_if ? 4'hF : v.be;
      e_wd   = v.exp_if ? 32'h0 : v.wd;
      tick();
      if (v.exp_if) if_req = 1'b0; else d_req = 1'b0;
      done = 1'b0;
      for (int k = 1; k <= TMO && !done; k++) begin
        ack = (k == v.stall + 1);
        mem_ack = ack;
        mem_rdata = ack ? v.rd : (32'hBAD0_0000 + 32'(k));
        @(negedge clk);
        chk($sformatf("v%0d_busy%0d_mem_req", i, k), 64'(mem_req), 64'd1);
        chk($sformatf("v%0d_busy%0d_payload", i, k),
            {mem_we, mem_be, mem_addr, 27'(mem_wdata)}, {e_we, e_be, e_addr, 27'(e_wd)});
        chk($sformatf("v%0d_busy%0d_wdata", i, k), 64'(mem_wdata), 64'(e_wd));
        chk($sformatf("v%0d_busy%0d_quiet", i, k),
            64'({if_gnt, d_gnt, if_rvalid, d_rvalid}), 64'd0);
        tick();
        if (ack) done = 1'b1;
      end
      // RESP cycle: an ack here must be ignored
      mem_ack = 1'b1;
      mem_rdata = 32'h5555_AAAA;
      exp_rd = v.exp_err ? 32'h0 : v.rd;
      @(negedge clk);
      chk($sformatf("v%0d_resp_mem_req", i), 64'(mem_req), 64'd0);
      if (v.exp_if) begin
        chk($sformatf("v%0d_if_rvalid", i), 64'({if_rvalid, if_err}), 64'({1'b1, v.exp_err}));
        chk($sformatf("v%0d_if_rdata", i),  64'(if_rdata), 64'(exp_rd));
        chk($sformatf("v%0d_d_quiet", i),   64'({d_rvalid, d_err}), 64'd0);
        chk($sformatf("v%0d_d_hold", i),    64'(d_rdata), 64'(tb_d_rd));
        tb_if_rd = exp_rd;
      end else begin
        chk($sformatf("v%0d_d_rvalid", i),  64'({d_rvalid, d_err}), 64'({1'b1, v.exp_err}));
        chk($sformatf("v%0d_d_rdata", i),   64'(d_rdata), 64'(exp_rd));
        chk($sformatf("v%0d_if_quiet", i),  64'({if_rvalid, if_err}), 64'd0);
        chk($sformatf("v%0d_if_hold", i),   64'(if_rdata), 64'(tb_if_rd));
        tb_d_rd = exp_rd;
      end
      tick();
      // back in IDLE: the strobes must have dropped after one cycle
      mem_ack = 1'b0;
    end
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("idle_after_table", 64'({if_rvalid, d_rvalid, if_err, d_err, mem_req}), 64'd0);
    tick();

    // ---------------- reset during BUSY_IF ----------------
    if_req = 1'b1; if_addr = 32'h0000_0040;
    @(negedge clk);
    chk("rst_seq_if_gnt", 64'(if_gnt), 64'd1);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    chk("rst_seq_busy", 64'(mem_req), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500; d_be = 4'hF;
    mem_ack = 1'b1; mem_rdata = 32'h0000_0999;
    tick();
    chk_all_zero("held_rst");
    reset = 1'b1;
    @(negedge clk);
    chk("post_rel_no_gnt", 64'({if_gnt, d_gnt}), 64'd0);
    chk("post_rel_no_rvalid", 64'({if_rvalid, if_err}), 64'd0);
    tick();
    @(negedge clk);
    chk("post_rel_tie_gnt", 64'({if_gnt, d_gnt}), 64'b01);
    chk("post_rel_stale", 64'(if_rvalid), 64'd0);
    tick();
    d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_0077;
    @(negedge clk);
    chk("post_rel_busy", 64'({mem_req, if_rvalid}), 64'b10);
    tick();
    mem_ack = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("post_rel_d_resp", 64'({d_rvalid, d_err, if_rvalid}), 64'b100);
    chk("post_rel_d_rdata", 64'(d_rdata), 64'h77);

    // ---------------- randomized run vs. timeline model ----------------
    #1 reset = 1'b0;
    if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    in_txn = 0; last_was_if = 1; tb_if_rd = '0; tb_d_rd = '0; noack = 0;
    gcyc = 0; end_k = 0; own_if = 0; exp_err_m = 0;
    for (int cyc = 0; cyc < NRAND; cyc++) begin
      if (!if_req && ($urandom % 3 == 0)) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (!d_req && ($urandom % 3 == 0)) begin
        d_req = 1'b1; d_we = 1'($urandom); d_addr = $urandom;
        d_wdata = $urandom; d_be = 4'($urandom);
      end
      mem_ack = !(in_txn && noack) && ($urandom % 4 == 0);
      mem_rdata = $urandom;
      @(negedge clk);

      e_gi = 0; e_gd = 0;
      if (!in_txn) begin
        if (if_req && d_req) begin
          if (last_was_if) e_gd = 1; else e_gi = 1;
        end else begin
          e_gi = if_req; e_gd = d_req;
        end
      end
      busy = in_txn && (end_k == 0) && (cyc > gcyc);
      resp = in_txn && (end_k != 0) && (cyc == gcyc + end_k + 1);

      chk("rnd_gnt", 64'({if_gnt, d_gnt}), 64'({e_gi, e_gd}));
      chk("rnd_mem_req", 64'(mem_req), 64'(busy));
      if (busy) begin
        chk("rnd_payload", {mem_we, mem_be, mem_addr}, {27'd0, e_we, e_be, e_addr});
        chk("rnd_wdata", 64'(mem_wdata), 64'(e_wd));
      end
      chk("rnd_if_resp", 64'({if_rvalid, if_err}),
          64'({resp && own_if, resp && own_if && exp_err_m}));
      chk("rnd_d_resp", 64'({d_rvalid, d_err}),
          64'({resp && !own_if, resp && !own_if && exp_err_m}));
      chk("rnd_rdata", {if_rdata, d_rdata}, {tb_if_rd, tb_d_rd});

      if (busy) begin
        if (mem_ack) begin
          end_k = cyc - gcyc; exp_err_m = 0;
          if (own_if) tb_if_rd = mem_rdata; else tb_d_rd = mem_rdata;
        end else if (cyc - gcyc == TMO) begin
          end_k = cyc - gcyc; exp_err_m = 1;
          if (own_if) tb_if_rd = '0; else tb_d_rd = '0;
        end
      end else if (resp) begin
        in_txn = 0;
      end
      if (e_gi || e_gd) begin
        in_txn = 1; gcyc = cyc; end_k = 0; own_if = e_gi; last_was_if = e_gi;
        noack = ($urandom % 5 == 0);
        e_addr = e_gi ? if_addr : d_addr;
        e_we   = e_gi ? 1'b0 : d_we;
        e_be   = e_gi ? 4'hF : d_be;
        e_wd   = e_gi ? 32'h0 : d_wdata;
      end
      tick();
      if (e_gi) if_req = 1'b0;
      if (e_gd) d_req = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
